// File: rtl/vga_ram_scanner.sv
// vga_ram_scanner
//   Display-side reader of the frame-buffer RAM. It generates VGA timing
//   (640x480@60 by default) from the system clock. For each scanned pixel it
//   drives the RAM read address of the cell that pixel lies in, then turns the
//   returned word into 1-bit R/G/B with sync signals aligned to the colour.
//
//   Optional feature: define VGA_RAM_SCANNER_BORDER_EN to draw a one-pixel
//   white frame around the visible area. The border overrides RAM data; the
//   read address is unaffected.
//
// Ports
//   Clock        : system clock, rising edge
//   Reset_n      : asynchronous active-low reset
//   oReadAddress : RAM read address (registered)
//   iDataIn      : RAM read data, valid one Clock after the address; [2:0] = RGB
//   oRed/oGreen/oBlue : colour outputs, forced to 0 outside the visible area
//   oHSync/oVSync     : active-low syncs, aligned with colour
//   oVisible          : output pixel lies in the visible area
//   oVBlankStart      : one-Clock pulse when vertical blanking begins
module vga_ram_scanner #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int CLK_DIV    = 2,
  parameter int CELL_SHIFT = 5,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  output logic                  oRed,
  output logic                  oGreen,
  output logic                  oBlue,
  output logic                  oHSync,
  output logic                  oVSync,
  output logic                  oVisible,
  output logic                  oVBlankStart
);

  localparam int HT      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CELLS_X = H_VISIBLE >> CELL_SHIFT;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(HT);
  localparam int VW      = $clog2(VT);

  logic [DW-1:0]         div_r;
  logic [HW-1:0]         hcount_r;
  logic [VW-1:0]         vcount_r;
  logic                  tick_s;
  logic                  vis_a_s;
  logic                  hs_a_s;
  logic                  vs_a_s;
  logic                  vblank_a_s;
  logic [31:0]           cell_x_s;
  logic [31:0]           cell_y_s;
  logic [31:0]           addr_full_s;
  logic [ADDR_WIDTH-1:0] addr_a_s;
  logic [2:0]            rgb_b_s;
  logic                  vis_a_r;
  logic                  hs_a_r;
  logic                  vs_a_r;
  logic                  unused_data_s;

  // Colour lives in the low three bits; the rest of the word belongs to the writer.
  assign unused_data_s = ^iDataIn[DATA_WIDTH-1:3];

  assign tick_s = (div_r == DW'(CLK_DIV - 1));

  // Stage A decode of the pixel currently addressed by the counters.
  always_comb begin
    vis_a_s = (hcount_r < HW'(H_VISIBLE)) && (vcount_r < VW'(V_VISIBLE));
    hs_a_s  = !((hcount_r >= HW'(H_VISIBLE + H_FRONT)) &&
                (hcount_r <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
    vs_a_s  = !((vcount_r >= VW'(V_VISIBLE + V_FRONT)) &&
                (vcount_r <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));
    vblank_a_s  = tick_s && (hcount_r == HW'(0)) && (vcount_r == VW'(V_VISIBLE));
    cell_x_s    = 32'(hcount_r >> CELL_SHIFT);
    cell_y_s    = 32'(vcount_r >> CELL_SHIFT);
    addr_full_s = cell_y_s * 32'(CELLS_X) + cell_x_s;
    if (vis_a_s) begin
      addr_a_s = addr_full_s[ADDR_WIDTH-1:0];
    end else begin
      addr_a_s = '0;
    end
  end

`ifdef VGA_RAM_SCANNER_BORDER_EN
  logic border_a_s;
  logic border_a_r;

  // Outermost visible rows/columns form the border.
  always_comb begin
    border_a_s = vis_a_s &&
                 ((hcount_r == HW'(0)) || (hcount_r == HW'(H_VISIBLE - 1)) ||
                  (vcount_r == VW'(0)) || (vcount_r == VW'(V_VISIBLE - 1)));
  end

  // Border flag travels with the pixel through stage A.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      border_a_r <= 1'b0;
    end else if (tick_s) begin
      border_a_r <= border_a_s;
    end
  end

  // Stage B colour: border is white, otherwise RAM colour gated by visibility.
  always_comb begin
    if (border_a_r) begin
      rgb_b_s = 3'b111;
    end else begin
      rgb_b_s = {3{vis_a_r}} & iDataIn[2:0];
    end
  end
`else
  // Stage B colour: RAM colour gated by visibility so blanking is always black.
  always_comb begin
    rgb_b_s = {3{vis_a_r}} & iDataIn[2:0];
  end
`endif

  // Pixel divider and raster counters; counters move only on pixel ticks.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      div_r    <= '0;
      hcount_r <= '0;
      vcount_r <= '0;
    end else begin
      if (tick_s) begin
        div_r <= '0;
        if (hcount_r == HW'(HT - 1)) begin
          hcount_r <= '0;
          if (vcount_r == VW'(VT - 1)) begin
            vcount_r <= '0;
          end else begin
            vcount_r <= vcount_r + VW'(1);
          end
        end else begin
          hcount_r <= hcount_r + HW'(1);
        end
      end else begin
        div_r <= div_r + DW'(1);
      end
    end
  end

  // Stage A registers: read address plus visibility/sync delayed to meet RAM data.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      oReadAddress <= '0;
      vis_a_r      <= 1'b0;
      hs_a_r       <= 1'b1;
      vs_a_r       <= 1'b1;
    end else if (tick_s) begin
      oReadAddress <= addr_a_s;
      vis_a_r      <= vis_a_s;
      hs_a_r       <= hs_a_s;
      vs_a_r       <= vs_a_s;
    end
  end

  // Stage B registers: colour and syncs leave together, two ticks after the counters.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      oRed     <= 1'b0;
      oGreen   <= 1'b0;
      oBlue    <= 1'b0;
      oHSync   <= 1'b1;
      oVSync   <= 1'b1;
      oVisible <= 1'b0;
    end else if (tick_s) begin
      oRed     <= rgb_b_s[2];
      oGreen   <= rgb_b_s[1];
      oBlue    <= rgb_b_s[0];
      oHSync   <= hs_a_r;
      oVSync   <= vs_a_r;
      oVisible <= vis_a_r;
    end
  end

  // Vertical-blank pulse: set on the qualifying tick, cleared on the next Clock.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      oVBlankStart <= 1'b0;
    end else begin
      oVBlankStart <= vblank_a_s;
    end
  end

endmodule

// File: tb/tb_vga_ram_scanner.sv
// Self-checking bench for vga_ram_scanner using a reduced raster so that
// several whole frames fit in a short run. A raster model derives each
// pixel's expected outputs from its index; a monitor compares them.
module tb_vga_ram_scanner;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 48, VF = 2, VS = 2, VB = 3;
  localparam int CS = 3, DIV = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int CX = HV >> CS;
  localparam int FRAME_CLK = HT * VT * DIV;

  logic        Clock;
  logic        Reset_n;
  logic [8:0]  oReadAddress;
  logic [15:0] iDataIn;
  logic        oRed, oGreen, oBlue, oHSync, oVSync, oVisible, oVBlankStart;

  vga_ram_scanner #(
    .DATA_WIDTH(16), .ADDR_WIDTH(9), .CLK_DIV(DIV), .CELL_SHIFT(CS),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .oReadAddress(oReadAddress),
    .iDataIn(iDataIn), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oHSync(oHSync), .oVSync(oVSync), .oVisible(oVisible),
    .oVBlankStart(oVBlankStart)
  );

  logic [15:0] mem [0:511];
  int          checks;
  int          failures;
  int          e_cnt;
  bit          running;
  logic [5:0]  out_q [$];
  logic [9:0]  cyc_q [$];
  logic [5:0]  last_out;
  logic [8:0]  model_addr;
  int          vb_seen;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Frame-buffer RAM with one-cycle registered read.
  always @(posedge Clock) iDataIn <= mem[oReadAddress];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    check("reset_state",
          {23'd0, oReadAddress, oRed, oGreen, oBlue, oHSync, oVSync, oVisible, oVBlankStart},
          {23'd0, 9'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic release_reset();
    @(negedge Clock);
    #2;
    out_q.delete();
    cyc_q.delete();
    e_cnt      = 0;
    model_addr = 9'd0;
    last_out   = 6'b000110;
    Reset_n    = 1'b1;
    running    = 1'b1;
  endtask

  task automatic assert_reset();
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    running = 1'b0;
    #1;
    check_reset();
  endtask

  // Raster model: the k-th pixel tick after reset release scans pixel k-1,
  // whose (h,v) follow directly from its index.
  initial begin
    int p, h, v, a;
    bit vis, hs, vs, vb;
    logic [2:0] col;
    logic [8:0] a9;
    forever begin
      @(posedge Clock);
      if (running) begin
        e_cnt++;
        @(negedge Clock);
        if (running) begin
          vb = 1'b0;
          if (e_cnt % DIV == 0) begin
            p   = e_cnt / DIV - 1;
            h   = p % HT;
            v   = (p / HT) % VT;
            vis = (h < HV) && (v < VV);
            a   = vis ? (v >> CS) * CX + (h >> CS) : 0;
            a9  = 9'(a);
            col = vis ? mem[a9][2:0] : 3'b000;
`ifdef VGA_RAM_SCANNER_BORDER_EN
            if (vis && (h == 0 || h == HV - 1 || v == 0 || v == VV - 1)) col = 3'b111;
`endif
            hs  = !((h >= HV + HF) && (h < HV + HF + HS));
            vs  = !((v >= VV + VF) && (v < VV + VF + VS));
            out_q.push_back({col, hs, vs, vis});
            model_addr = a9;
            vb = (h == 0) && (v == VV);
          end
          cyc_q.push_back({vb, model_addr});
        end
      end
    end
  end

  // Monitor: address/vblank checked every Clock; pixel outputs checked every
  // Clock against the newest pixel that has reached the pins.
  initial begin
    logic [9:0] c;
    forever begin
      @(negedge Clock);
      #1;
      if (running) begin
        if (cyc_q.size() > 0) begin
          c = cyc_q.pop_front();
          check("vblank", {31'd0, oVBlankStart}, {31'd0, c[9]});
          check("read_addr", {23'd0, oReadAddress}, {23'd0, c[8:0]});
          if (c[9]) vb_seen++;
        end
        if (out_q.size() >= 2) last_out = out_q.pop_front();
        check("pixel_rgb_hs_vs_vis",
              {26'd0, oRed, oGreen, oBlue, oHSync, oVSync, oVisible},
              {26'd0, last_out});
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    running  = 1'b0;
    vb_seen  = 0;
    e_cnt    = 0;
    Reset_n  = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    repeat (2) @(negedge Clock);
    #1;
    check_reset();
    repeat (3) @(negedge Clock);
    #1;
    check_reset();

    // Random frame contents over two frames, then reset mid-frame at line 20.
    release_reset();
    repeat (2 * FRAME_CLK + 20 * HT * DIV + 37) @(posedge Clock);
    check("vblank_count_2_frames", vb_seen, 2);
    assert_reset();
    repeat (3) @(posedge Clock);
    #1;
    check_reset();

    // All-ones RAM: colour only inside the visible area.
    for (int i = 0; i < 512; i++) mem[i] = 16'hFFFF;
    release_reset();
    repeat (FRAME_CLK + 200) @(posedge Clock);
    assert_reset();
    repeat (3) @(posedge Clock);

    // All-zero RAM: black, except the border when that feature is built in.
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    release_reset();
    repeat (FRAME_CLK + 200) @(posedge Clock);
    assert_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
